abdiskiosk_test: RTL and testbench

//  Tiny Tapeout user top: an 8-bit accumulator ALU driven from the dedicated and bidirectional pins.

---
 rtl/abdiskiosk_pkg.sv | 31 +++
 rtl/abdiskiosk_alu.sv | 65 ++++++
 rtl/abdiskiosk_test.sv | 64 ++++++
 tb/tb_abdiskiosk_test.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/abdiskiosk_pkg.sv
// Shared opcode encoding, pin constants and helpers for the abdiskiosk accumulator ALU.
// Optional feature: define ABDISKIOSK_SAT_EN for saturating ADD/SUB/INC/DEC.
package abdiskiosk_pkg;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_LOAD = 4'd1,
        OP_ADD  = 4'd2,
        OP_SUB  = 4'd3,
        OP_AND  = 4'd4,
        OP_OR   = 4'd5,
        OP_XOR  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_INC  = 4'd9,
        OP_DEC  = 4'd10,
        OP_CLR  = 4'd11
    } op_e;

    localparam logic [7:0] UIO_OE_MASK = 8'hE0;
    localparam int EXEC_BIT = 4;
    localparam int Z_BIT    = 5;
    localparam int C_BIT    = 6;
    localparam int DONE_BIT = 7;

    // Codes 12-15 are reserved and behave exactly like OP_NOP.
    function automatic logic is_nop(input logic [3:0] op);
        return (op == OP_NOP) || (op > OP_CLR);
    endfunction

endpackage

// File: rtl/abdiskiosk_alu.sv
// Combinational accumulator ALU: computes the next ACC value and its C/Z flags.
// ABDISKIOSK_SAT_EN selects clamping instead of modulo-256 wrap for ADD/SUB/INC/DEC.
module abdiskiosk_alu
    import abdiskiosk_pkg::*;
(
    input  logic [7:0] acc,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] res,
    output logic       c,
    output logic       z
);

    logic [8:0] sum;
    logic [8:0] diff;

    assign sum  = {1'b0, acc} + {1'b0, b};
    assign diff = {1'b0, acc} - {1'b0, b};

    // NOTE: res and c get defaults before the case so no path leaves them unassigned (no latch).
    always_comb begin
        res = acc;
        c   = 1'b0;
        case (op)
            OP_LOAD: res = b;
            OP_ADD: begin
                res = sum[7:0];
                c   = sum[8];
            end
            OP_SUB: begin
                res = diff[7:0];
                c   = diff[8];
            end
            OP_AND:  res = acc & b;
            OP_OR:   res = acc | b;
            OP_XOR:  res = acc ^ b;
            OP_SHL: begin
                res = {acc[6:0], 1'b0};
                c   = acc[7];
            end
            OP_SHR: begin
                res = {1'b0, acc[7:1]};
                c   = acc[0];
            end
            OP_INC: begin
                res = acc + 8'd1;
                c   = (acc == 8'hFF);
            end
            OP_DEC: begin
                res = acc - 8'd1;
                c   = (acc == 8'h00);
            end
            OP_CLR:  res = 8'h00;
            default: ;
        endcase
`ifdef ABDISKIOSK_SAT_EN
        // C still reports the overflow/borrow; only the value is clamped.
        if (c && (op == OP_ADD || op == OP_INC)) res = 8'hFF;
        if (c && (op == OP_SUB || op == OP_DEC)) res = 8'h00;
`endif
    end

    assign z = (res == 8'h00);

endmodule

// File: rtl/abdiskiosk_test.sv
// Tiny Tapeout top: 8-bit accumulator fired by a rising edge of EXEC (uio_in[4]).
// Build option ABDISKIOSK_SAT_EN enables saturating arithmetic in the ALU.
module abdiskiosk_test
    import abdiskiosk_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] acc;
    logic       z_q;
    logic       c_q;
    logic       done_q;
    logic       exec_q;
    logic       fire;
    logic [7:0] alu_res;
    logic       alu_c;
    logic       alu_z;
    logic       unused_pins;

    abdiskiosk_alu u_alu (
        .acc (acc),
        .b   (ui_in),
        .op  (uio_in[3:0]),
        .res (alu_res),
        .c   (alu_c),
        .z   (alu_z)
    );

    // exec_q resets high so an EXEC held through reset is not seen as a rising edge.
    assign fire = ena & uio_in[EXEC_BIT] & ~exec_q;

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= 8'h00;
            z_q    <= 1'b1;
            c_q    <= 1'b0;
            done_q <= 1'b0;
            exec_q <= 1'b1;
        end else begin
            exec_q <= uio_in[EXEC_BIT];
            done_q <= fire;
            if (fire && !is_nop(uio_in[3:0])) begin
                acc <= alu_res;
                c_q <= alu_c;
                z_q <= alu_z;
            end
        end
    end

    assign uo_out  = acc;
    assign uio_out = {done_q, c_q, z_q, 5'b0_0000};
    assign uio_oe  = UIO_OE_MASK;

    assign unused_pins = &{1'b0, uio_in[7:5]};

endmodule

// File: tb/tb_abdiskiosk_test.sv
// Self-checking bench for abdiskiosk_test: directed scenarios plus random ops against an integer model.
// Define ABDISKIOSK_SAT_EN for both bench and RTL to check the saturating build.
module tb_abdiskiosk_test;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state kept as plain integers.
    int m_acc;
    int m_c;
    int m_z;

    abdiskiosk_test dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] status(input int done);
        logic [7:0] s;
        s = 8'h00;
        s[7] = (done != 0);
        s[6] = (m_c != 0);
        s[5] = (m_z != 0);
        return s;
    endfunction

    task automatic model_reset();
        m_acc = 0;
        m_c   = 0;
        m_z   = 1;
    endtask

    // Applies one fired opcode to the reference state using integer arithmetic.
    task automatic model_op(input int op, input int b);
        int r;
        int s;
        bit sat;
`ifdef ABDISKIOSK_SAT_EN
        sat = 1'b1;
`else
        sat = 1'b0;
`endif
        r = m_acc;
        case (op)
            1: begin r = b; m_c = 0; end
            2, 9: begin
                s   = m_acc + ((op == 2) ? b : 1);
                m_c = (s > 255);
                r   = (m_c != 0 && sat) ? 255 : s % 256;
            end
            3, 10: begin
                s   = m_acc - ((op == 3) ? b : 1);
                m_c = (s < 0);
                r   = (m_c != 0 && sat) ? 0 : (s + 256) % 256;
            end
            4: begin r = m_acc & b; m_c = 0; end
            5: begin r = m_acc | b; m_c = 0; end
            6: begin r = m_acc ^ b; m_c = 0; end
            7: begin r = (m_acc * 2) % 256; m_c = (m_acc >= 128); end
            8: begin r = m_acc / 2; m_c = m_acc % 2; end
            11: begin r = 0; m_c = 0; end
            default: return;
        endcase
        m_acc = r;
        m_z   = (r == 0);
    endtask

    // One EXEC pulse (one cycle high) with the given opcode and operand.
    task automatic exec_op(input string tag, input int op, input int b, input bit en);
        @(negedge clk);
        ui_in  = 8'(b);
        uio_in = {3'($urandom), 1'b1, 4'(op)};
        ena    = en;
        if (en) model_op(op, b);
        @(posedge clk);
        #1;
        check({tag, " acc"}, uo_out, 8'(m_acc));
        check({tag, " flags"}, uio_out, status(en ? 1 : 0));
        @(negedge clk);
        uio_in[4] = 1'b0;
        @(posedge clk);
        #1;
        check({tag, " done clears"}, uio_out, status(0));
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h10;
        model_reset();

        // Reset with EXEC held high: no fire after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset acc", uo_out, 8'h00);
            check("reset status", uio_out, 8'h20);
        end
        check("uio_oe", uio_oe, 8'hE0);
        @(negedge clk);
        uio_in = 8'h00;
        @(posedge clk);

        exec_op("load 7f", 1, 8'h7F, 1'b1);
        exec_op("add 01", 2, 8'h01, 1'b1);
        exec_op("load ff", 1, 8'hFF, 1'b1);
        exec_op("add carry", 2, 8'h01, 1'b1);
        exec_op("load 05", 1, 8'h05, 1'b1);
        exec_op("sub borrow", 3, 8'h06, 1'b1);
        exec_op("load 81", 1, 8'h81, 1'b1);
        exec_op("shl", 7, 8'h00, 1'b1);
        exec_op("shr", 8, 8'h00, 1'b1);
        exec_op("nop", 0, 8'h00, 1'b1);
        exec_op("dec", 10, 8'h00, 1'b1);
        exec_op("dec zero", 10, 8'h00, 1'b1);

        // EXEC held high for 10 cycles with INC: one increment only.
        @(negedge clk);
        uio_in = {3'b000, 1'b1, 4'd9};
        model_op(9, 0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold acc", uo_out, 8'(m_acc));
            check("hold flags", uio_out, status((i == 0) ? 1 : 0));
        end
        @(negedge clk);
        uio_in[4] = 1'b0;
        @(posedge clk);

        exec_op("ena low", 9, 8'h00, 1'b0);
        exec_op("rearm inc", 9, 8'h00, 1'b1);

        for (int i = 0; i < 80; i++)
            exec_op("random", int'($urandom_range(0, 15)), int'($urandom_range(0, 255)),
                    ($urandom_range(0, 7) != 0));

        // Asynchronous reset between clock edges.
        exec_op("load 55", 1, 8'h55, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("async reset acc", uo_out, 8'h00);
        check("async reset status", uio_out, 8'h20);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        exec_op("post reset load", 1, 8'hA5, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
